// File: rtl/fifo_rd_tx.sv
// Drains a FIFO into a UART transmitter in bursts once almost_full has been synchronised.
// The burst waits DLY_CNT+1 cycles to settle, then reads, latches and sends bytes until the FIFO is empty.
module fifo_rd_tx #(
  parameter int DLY_CNT = 10,
  parameter int DATA_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              almost_full,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              tx_busy,
  output logic              fifo_rd_en,
  output logic              uart_tx_en,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              fifo_rd_ok,
  output logic [8:0]        rd_cnt
);

  typedef enum logic [2:0] {
    IDLE, DLY, RD, LATCH, SEND, BUSY_HI, BUSY_LO, DONE
  } state_e;

  localparam logic [3:0] DLY_END = 4'(DLY_CNT);

  state_e            state_q, state_d;
  logic              af_d0_q, af_d0_d;
  logic              af_d1_q, af_d1_d;
  logic [3:0]        dly_cnt_q, dly_cnt_d;
  logic              to_q, to_d;
  logic [8:0]        rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] uart_tx_data_q, uart_tx_data_d;
  logic              uart_tx_en_q, uart_tx_en_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              fifo_rd_ok_q, fifo_rd_ok_d;

  always_comb begin
    state_d        = state_q;
    af_d0_d        = almost_full;
    af_d1_d        = af_d0_q;
    dly_cnt_d      = dly_cnt_q;
    to_d           = to_q;
    rd_cnt_d       = rd_cnt_q;
    uart_tx_data_d = uart_tx_data_q;
    uart_tx_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (af_d1_q) begin
          state_d   = DLY;
          rd_cnt_d  = '0;
          dly_cnt_d = '0;
        end
      end
      DLY: begin
        if (dly_cnt_q == DLY_END) begin
          dly_cnt_d = '0;
          state_d   = RD;
        end else begin
          dly_cnt_d = dly_cnt_q + 4'd1;
        end
      end
      RD:    state_d = fifo_rd_en_q ? LATCH : DONE;
      LATCH: begin
        uart_tx_data_d = fifo_rd_data;
        state_d        = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          uart_tx_en_d = 1'b1;
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 9'd1;
          to_d    = 1'b0;
          state_d = BUSY_HI;
        end
      end
      BUSY_HI: begin
        if (tx_busy)   state_d = BUSY_LO;
        else if (to_q) state_d = RD;
        else           to_d    = 1'b1;
      end
      BUSY_LO: if (!tx_busy) state_d = RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read strobe is decided on the way into RD so it is registered yet high during RD.
    // A stale !empty is safe: only this block removes data from the FIFO.
    fifo_rd_en_d = (state_d == RD) && !empty;
    fifo_rd_ok_d = (state_d == DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      af_d0_q        <= 1'b0;
      af_d1_q        <= 1'b0;
      dly_cnt_q      <= '0;
      to_q           <= 1'b0;
      rd_cnt_q       <= '0;
      uart_tx_data_q <= '0;
      uart_tx_en_q   <= 1'b0;
      fifo_rd_en_q   <= 1'b0;
      fifo_rd_ok_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      af_d0_q        <= af_d0_d;
      af_d1_q        <= af_d1_d;
      dly_cnt_q      <= dly_cnt_d;
      to_q           <= to_d;
      rd_cnt_q       <= rd_cnt_d;
      uart_tx_data_q <= uart_tx_data_d;
      uart_tx_en_q   <= uart_tx_en_d;
      fifo_rd_en_q   <= fifo_rd_en_d;
      fifo_rd_ok_q   <= fifo_rd_ok_d;
    end
  end

  assign fifo_rd_en   = fifo_rd_en_q;
  assign uart_tx_en   = uart_tx_en_q;
  assign uart_tx_data = uart_tx_data_q;
  assign fifo_rd_ok   = fifo_rd_ok_q;
  assign rd_cnt       = rd_cnt_q;

endmodule
